// File: rtl/amiga_eclk_cycle_if.sv
// CPU-side handshake bundle for the E-clock peripheral cycle engine.
//   req   : CPU cycle request (level, four-phase handshake)
//   rw    : 1 = read, 0 = write, sampled with req
//   wdata : CPU write data, sampled with req
//   rdata : captured CIA read data
//   ack   : cycle-complete acknowledge
//   busy  : engine is not idle
// The master modport is the CPU view. The slave modport is the cycle engine view.
interface amiga_eclk_cycle_if;
    logic       req;
    logic       rw;
    logic [7:0] wdata;
    logic [7:0] rdata;
    logic       ack;
    logic       busy;

    modport master (
        output req, rw, wdata,
        input  rdata, ack, busy
    );

    modport slave (
        input  req, rw, wdata,
        output rdata, ack, busy
    );
endinterface

// File: rtl/amiga_eclk_cycle.sv
// E-clock synchronised CIA access engine.
// The engine accepts a CPU request and aligns it to the 10-phase E clock.
// It drives vma and a single cia_en strobe to the CIA, then completes a
// four-phase ack handshake with the CPU.
//
// Ports
//   clk_28    : 28 MHz clock, sole clock
//   reset_n   : asynchronous active-low reset
//   clk7_en   : 7 MHz enable, one clk_28 cycle in four ("tick")
//   eclk      : one-hot E phase vector, bit k = phase k
//   cpu       : CPU handshake (req/rw/wdata in, rdata/ack/busy out)
//   cia_dout  : CIA read data
//   e         : registered E clock level (phases 6..9)
//   vma       : valid memory address to CIA
//   cia_rw    : latched rw
//   cia_din   : latched write data
//   cia_en    : CIA access strobe, one clk_28 cycle wide
//
// state  | meaning
// IDLE   | waiting for req on a tick
// SYNC   | request latched, waiting for the VMA_PHASE tick
// ACCESS | vma asserted, waiting for the STROBE_PHASE tick
// ACK    | strobe done, ack held until req drops
module amiga_eclk_cycle #(
    parameter int VMA_PHASE    = 2,
    parameter int STROBE_PHASE = 9
) (
    input  logic              clk_28,
    input  logic              reset_n,
    input  logic              clk7_en,
    input  logic [9:0]        eclk,
    amiga_eclk_cycle_if.slave cpu,
    input  logic [7:0]        cia_dout,
    output logic              e,
    output logic              vma,
    output logic              cia_rw,
    output logic [7:0]        cia_din,
    output logic              cia_en
);

    // Phases are matched on the exact one-hot value. An all-zero or
    // multi-hot eclk therefore matches nothing, and the FSM holds.
    localparam logic [9:0] VMA_HOT    = 10'b1 << VMA_PHASE;
    localparam logic [9:0] STROBE_HOT = 10'b1 << STROBE_PHASE;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SYNC   = 2'd1,
        ACCESS = 2'd2,
        ACK    = 2'd3
    } state_t;

    state_t     state_q, state_d;
    logic       vma_q, vma_d;
    logic       ack_q, ack_d;
    logic       cia_en_q, cia_en_d;
    logic       cia_rw_q, cia_rw_d;
    logic       e_q, e_d;
    logic [7:0] cia_din_q, cia_din_d;
    logic [7:0] rdata_q, rdata_d;
    logic       at_vma;
    logic       at_strobe;

    assign at_vma    = (eclk == VMA_HOT);
    assign at_strobe = (eclk == STROBE_HOT);

    always_comb begin
        state_d   = state_q;
        vma_d     = vma_q;
        ack_d     = ack_q;
        cia_en_d  = 1'b0;
        cia_rw_d  = cia_rw_q;
        cia_din_d = cia_din_q;
        rdata_d   = rdata_q;
        e_d       = |eclk[9:6];

        if (clk7_en) begin
            case (state_q)
                IDLE: begin
                    if (cpu.req) begin
                        state_d   = SYNC;
                        cia_rw_d  = cpu.rw;
                        cia_din_d = cpu.wdata;
                    end
                end
                SYNC: begin
                    if (at_vma) begin
                        state_d = ACCESS;
                        vma_d   = 1'b1;
                    end
                end
                ACCESS: begin
                    if (at_strobe) begin
                        state_d  = ACK;
                        cia_en_d = 1'b1;
                        ack_d    = 1'b1;
                        if (cia_rw_q) begin
                            rdata_d = cia_dout;
                        end
                    end
                end
                ACK: begin
                    // The first tick in ACK always drops vma. Later ticks
                    // only wait for the CPU to release req.
                    vma_d = 1'b0;
                    if (!cpu.req) begin
                        state_d = IDLE;
                        ack_d   = 1'b0;
                    end
                end
                default: state_d = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk_28 or negedge reset_n) begin
        if (!reset_n) begin
            state_q   <= IDLE;
            vma_q     <= 1'b0;
            ack_q     <= 1'b0;
            cia_en_q  <= 1'b0;
            cia_rw_q  <= 1'b1;
            cia_din_q <= 8'h00;
            rdata_q   <= 8'h00;
            e_q       <= 1'b0;
        end else begin
            state_q   <= state_d;
            vma_q     <= vma_d;
            ack_q     <= ack_d;
            cia_en_q  <= cia_en_d;
            cia_rw_q  <= cia_rw_d;
            cia_din_q <= cia_din_d;
            rdata_q   <= rdata_d;
            e_q       <= e_d;
        end
    end

    assign e         = e_q;
    assign vma       = vma_q;
    assign cia_rw    = cia_rw_q;
    assign cia_din   = cia_din_q;
    assign cia_en    = cia_en_q;
    assign cpu.rdata = rdata_q;
    assign cpu.ack   = ack_q;
    assign cpu.busy  = (state_q != IDLE);

endmodule

// File: tb/tb_amiga_eclk_cycle.sv
// Self-checking bench for amiga_eclk_cycle.
// Each transaction is predicted arithmetically from the phase it is
// sampled at: the ticks to the next VMA phase, plus the VMA-to-strobe
// distance, plus the ticks until req is seen low.
module tb_amiga_eclk_cycle;

    localparam int VMA_PHASE    = 2;
    localparam int STROBE_PHASE = 9;

    logic       clk_28;
    logic       reset_n;
    logic       clk7_en;
    logic [9:0] eclk;
    logic [7:0] cia_dout;
    logic       e;
    logic       vma;
    logic       cia_rw;
    logic [7:0] cia_din;
    logic       cia_en;

    amiga_eclk_cycle_if bus ();

    amiga_eclk_cycle #(
        .VMA_PHASE    (VMA_PHASE),
        .STROBE_PHASE (STROBE_PHASE)
    ) dut (
        .clk_28   (clk_28),
        .reset_n  (reset_n),
        .clk7_en  (clk7_en),
        .eclk     (eclk),
        .cpu      (bus),
        .cia_dout (cia_dout),
        .e        (e),
        .vma      (vma),
        .cia_rw   (cia_rw),
        .cia_din  (cia_din),
        .cia_en   (cia_en)
    );

    int         n_chk = 0;
    int         n_err = 0;
    int         en_pulses = 0;
    int         phase;
    int         sub;
    bit         frozen;
    bit         rand_dout;
    logic [7:0] exp_rdata;

    initial clk_28 = 1'b0;
    always #5 clk_28 = ~clk_28;

    always @(negedge clk_28) begin
        if (cia_en) en_pulses++;
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
        end
    endtask

    task automatic chk_rst(input string t);
        chk({t, "_vma"},    32'(vma),       32'(1'b0));
        chk({t, "_cia_en"}, 32'(cia_en),    32'(1'b0));
        chk({t, "_ack"},    32'(bus.ack),   32'(1'b0));
        chk({t, "_busy"},   32'(bus.busy),  32'(1'b0));
        chk({t, "_e"},      32'(e),         32'(1'b0));
        chk({t, "_cia_rw"}, 32'(cia_rw),    32'(1'b1));
        chk({t, "_din"},    32'(cia_din),   32'(8'h00));
        chk({t, "_rdata"},  32'(bus.rdata), 32'(8'h00));
    endtask

    // One clk_28 cycle. The e flop is checked against the eclk that was
    // present at the edge. The stimulus (enable and E phase) is updated
    // 1 time unit after the edge.
    task automatic cyc();
        logic [9:0] prev_eclk;
        bit         was_tick;
        bit         was_rst;
        prev_eclk = eclk;
        was_tick  = clk7_en;
        was_rst   = reset_n;
        @(posedge clk_28);
        #1;
        if (was_rst && reset_n) chk("e", 32'(e), 32'(|prev_eclk[9:6]));
        if (was_tick && !frozen) begin
            phase = (phase + 1) % 10;
            eclk  = 10'b1 << phase;
        end
        sub     = (sub + 1) % 4;
        clk7_en = (sub == 3);
    endtask

    task automatic tick();
        bit done;
        done = 1'b0;
        while (!done) begin
            done = clk7_en;
            cyc();
        end
    endtask

    // Runs one cycle that is sampled when eclk presents phase p.
    //   hold : req is high on sample ticks 0..hold-1
    //   frz  : number of ticks with eclk forced to fpat after the sample;
    //          eclk then restarts at phase 0
    task automatic txn(input int p, input bit rw_v, input logic [7:0] wd, input int hold,
                       input int frz, input logic [9:0] fpat, output int lat);
        int d1, n_ack, clr, pulses0;
        lat = -1;
        while (phase != p) tick();
        bus.req   = 1'b1;
        bus.rw    = rw_v;
        bus.wdata = wd;
        if (rand_dout) cia_dout = 8'($urandom);
        if (frz > 0) d1 = frz + 1 + VMA_PHASE;
        else         d1 = 1 + (VMA_PHASE - (p + 1) % 10 + 10) % 10;
        n_ack   = d1 + STROBE_PHASE - VMA_PHASE;
        clr     = (hold > n_ack + 1) ? hold : n_ack + 1;
        pulses0 = en_pulses;
        for (int k = 0; k <= clr + 1; k++) begin
            tick();
            if (k == n_ack && rw_v) exp_rdata = cia_dout;
            chk("busy",   32'(bus.busy),  32'(k < clr));
            chk("vma",    32'(vma),       32'(k >= d1 && k <= n_ack));
            chk("ack",    32'(bus.ack),   32'(k >= n_ack && k < clr));
            chk("cia_en", 32'(cia_en),    32'(k == n_ack));
            chk("rdata",  32'(bus.rdata), 32'(exp_rdata));
            if (k <= clr) begin
                chk("cia_rw",  32'(cia_rw),  32'(rw_v));
                chk("cia_din", 32'(cia_din), 32'(wd));
            end
            if (bus.ack && lat < 0) lat = k;
            if (rand_dout) cia_dout = 8'($urandom);
            bus.req   = (k + 1 < hold);
            bus.rw    = 1'($urandom);
            bus.wdata = 8'($urandom);
            if (frz > 0 && k == 0) begin
                frozen = 1'b1;
                eclk   = fpat;
            end
            if (frz > 0 && k == frz) begin
                frozen = 1'b0;
                phase  = 0;
                eclk   = 10'h001;
            end
        end
        chk("ack_lat",  32'(lat), 32'(n_ack));
        chk("en_count", en_pulses - pulses0, 32'd1);
    endtask

    initial begin
        int         lat;
        int         pulses0;
        int         p, hold, frz;
        bit         rw_v;
        logic [7:0] wd;
        logic [9:0] fpat;

        reset_n   = 1'b1;
        clk7_en   = 1'b0;
        sub       = 0;
        phase     = 0;
        eclk      = 10'h001;
        frozen    = 1'b0;
        rand_dout = 1'b1;
        bus.req   = 1'b0;
        bus.rw    = 1'b0;
        bus.wdata = 8'h00;
        cia_dout  = 8'h00;
        exp_rdata = 8'h00;
        #1 reset_n = 1'b0;
        #1 chk_rst("por");
        repeat (3) cyc();
        reset_n = 1'b1;
        repeat (2) tick();
        chk("idle_busy", 32'(bus.busy), 32'(1'b0));

        // Read sampled at phase 1: minimum latency.
        rand_dout = 1'b0;
        cia_dout  = 8'hA5;
        txn(1, 1'b1, 8'h11, 1, 0, 10'h000, lat);
        chk("lat_min", 32'(lat), 32'd8);
        chk("rd_a5", 32'(bus.rdata), 32'(8'hA5));

        // Write sampled at phase 2: waits a full E period.
        cia_dout = 8'h5A;
        txn(2, 1'b0, 8'h3C, 18, 0, 10'h000, lat);
        chk("lat_max", 32'(lat), 32'd17);
        chk("rd_keep", 32'(bus.rdata), 32'(8'hA5));
        rand_dout = 1'b1;

        // req held 5 ticks past ack.
        txn(1, 1'b1, 8'h22, 8 + 6, 0, 10'h000, lat);

        // One-tick req pulse.
        txn(5, 1'b0, 8'h44, 1, 0, 10'h000, lat);

        // eclk stalled at zero for 20 ticks.
        txn(1, 1'b1, 8'h55, 40, 20, 10'h000, lat);

        // Reset during ACCESS.
        while (phase != 1) tick();
        bus.req   = 1'b1;
        bus.rw    = 1'b1;
        bus.wdata = 8'h77;
        repeat (4) tick();
        chk("acc_vma",  32'(vma),      32'(1'b1));
        chk("acc_busy", 32'(bus.busy), 32'(1'b1));
        #2 reset_n = 1'b0;
        #1 chk_rst("async");
        bus.req = 1'b0;
        cyc();
        cyc();
        reset_n   = 1'b1;
        exp_rdata = 8'h00;
        pulses0   = en_pulses;
        for (int i = 0; i < 15; i++) begin
            tick();
            chk("post_ack",  32'(bus.ack),  32'(1'b0));
            chk("post_busy", 32'(bus.busy), 32'(1'b0));
        end
        chk("post_en", en_pulses - pulses0, 32'd0);
        txn(3, 1'b1, 8'h66, 2, 0, 10'h000, lat);

        // Randomised cycles.
        for (int n = 0; n < 30; n++) begin
            p    = $urandom_range(0, 9);
            rw_v = 1'($urandom);
            wd   = 8'($urandom);
            hold = $urandom_range(1, 25);
            if ($urandom_range(0, 4) == 0) begin
                frz  = $urandom_range(1, 6);
                fpat = 10'($urandom);
                if ($onehot(fpat)) fpat = 10'h000;
            end else begin
                frz  = 0;
                fpat = 10'h000;
            end
            txn(p, rw_v, wd, hold, frz, fpat, lat);
        end

        $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
        $finish;
    end

endmodule
